alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
// - Shares one pipeline_alu instance between NUM_REQ requesters via round-robin arbitration.
// - Tags every issued op with its requester id and routes each ALU result back to that requester.
// - Sits between client blocks and pipeline_alu; the ALU is instantiated alongside it and wired to the o_alu_*/i_alu_* ports.
// - Includes an enable/drain FSM so software can quiesce the ALU cleanly.
// PARAMETERS
// - WIDTH      `WORD      operand/result width
// - OP_WIDTH   `OP_WIDTH  opcode width
// - NUM_REQ    2          requester count, 2..4
// - ALU_LAT    2          cycles from o_alu_valid to i_alu_valid (pipeline_alu latency)
// PORTS
// - i_clk          in   1               clock, rising edge
// - i_rst_n        in   1               asynchronous reset, active-low
// - i_enable       in   1               1 = grant requests; 0 = drain then idle
// - i_req_valid    in   NUM_REQ         per-requester op valid
// - o_req_ready    out  NUM_REQ         per-requester accept (one-hot or zero)
// - i_req_a        in   NUM_REQ*WIDTH   operand A, requester k at [k*WIDTH +: WIDTH]
// - i_req_b        in   NUM_REQ*WIDTH   operand B, same packing
// - i_req_op       in   NUM_REQ*OP_WIDTH opcode, requester k at [k*OP_WIDTH +: OP_WIDTH]
// - o_alu_a/o_alu_b out WIDTH           registered operands to ALU
// - o_alu_opcode   out  OP_WIDTH        registered opcode to ALU
// - o_alu_valid    out  1               registered issue strobe to ALU
// - i_alu_result   in   WIDTH           ALU result
// - i_alu_zero/i_alu_cf in 1            ALU flags
// - i_alu_valid    in   1               ALU result strobe
// - o_rsp_valid    out  NUM_REQ         one-hot response strobe
// - o_rsp_result   out  WIDTH           response data, shared by all requesters
// - o_rsp_zero/o_rsp_cf out 1           response flags
// - o_idle         out  1               FSM in IDLE, nothing in flight
// - o_err          out  1               sticky: ALU result with no matching tag, or tag with no result
// BEHAVIOUR
// - Reset (async, i_rst_n=0): all outputs 0; RR pointer=0; tag pipe cleared; FSM=IDLE; o_idle=1 once released.
// - FSM
//   - IDLE -> RUN when i_enable=1.
//   - RUN -> DRAIN when i_enable=0.
//   - DRAIN -> IDLE when the in-flight count reaches 0.
//   - DRAIN -> RUN if i_enable returns to 1.
// - Grant: combinational, RUN only. o_req_ready is one-hot to the first requester with valid=1, searching from the RR pointer upward with wrap. Handshake = valid & ready.
// - On handshake to requester k: pointer <= (k+1) mod NUM_REQ. The pointer holds when there is no grant.
// - Issue: the handshake at cycle T drives o_alu_* and o_alu_valid=1 at T+1; otherwise o_alu_valid=0 and operands hold.
// - Tag pipe: ALU_LAT+1 stages of {valid, id}. Stage 0 loads at issue; the tail aligns with i_alu_valid.
// - Response: registered. i_alu_valid at cycle R gives o_rsp_valid[id]=1 and data/flags at R+1.
//   - Total latency: handshake T -> response T+ALU_LAT+2 (T+4 at default).
// - Mismatch: i_alu_valid != tail.valid sets o_err=1 (sticky until reset). The response is suppressed when the tail is invalid.
// - In-flight counter: +1 on issue, -1 on response strobe, net 0 on the same cycle; max ALU_LAT+1.
// - Responses have no backpressure; requesters must accept o_rsp_valid unconditionally.
// - Requester k drops valid before the grant: nothing is issued; valid is not required to be sticky.
// CONFIGURATION
// - ALU_ARB_STATS_EN defined: adds output o_grant_cnt, NUM_REQ*16 bits. Each per-requester counter increments on handshake, saturates at 16'hFFFF, and resets to 0.
// - ALU_ARB_STATS_EN undefined: the port and counters are absent; all other behaviour is identical.
// TESTING
// - Single op: after reset, enable=1; req0 SUM a=2 b=2 at T -> o_alu_valid T+1, o_rsp_valid=2'b01, result=4 at T+4.
// - Contention: req0 SUM 2,2 and req1 SUB 7,2 held together -> ready0 first, then ready1; rsp[0]=4 at T+4, rsp[1]=5 at T+5.
// - Fairness: both requesters valid for 8 cycles -> grants alternate 0,1,0,1,... with no bubbles; XOR 8'h3C,8'h03 -> 8'h3F on each.
// - Drain: 2 ops in flight, drop i_enable -> ready stays 0; o_idle=1 the cycle after the last response; re-enable resumes granting.
// - Reset mid-flight: i_rst_n=0 with 3 ops in flight -> outputs 0 immediately; after release no stale o_rsp_valid ever appears.
// - Error: force i_alu_valid=1 with an empty tag pipe -> o_err=1 and stays 1; o_rsp_valid remains 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Client/ALU bus of alu_arbiter. The arbiter takes the slave modport; requesters
// and the pipeline_alu wrapper sit on the master side.
`ifndef WORD
`define WORD 8
`endif
`ifndef OP_WIDTH
`define OP_WIDTH 4
`endif

interface alu_arbiter_if #(
  parameter int WIDTH    = `WORD,
  parameter int OP_WIDTH = `OP_WIDTH,
  parameter int NUM_REQ  = 2
);
  logic [NUM_REQ-1:0]          i_req_valid;
  logic [NUM_REQ-1:0]          o_req_ready;
  logic [NUM_REQ*WIDTH-1:0]    i_req_a;
  logic [NUM_REQ*WIDTH-1:0]    i_req_b;
  logic [NUM_REQ*OP_WIDTH-1:0] i_req_op;
  logic [WIDTH-1:0]            o_alu_a;
  logic [WIDTH-1:0]            o_alu_b;
  logic [OP_WIDTH-1:0]         o_alu_opcode;
  logic                        o_alu_valid;
  logic [WIDTH-1:0]            i_alu_result;
  logic                        i_alu_zero;
  logic                        i_alu_cf;
  logic                        i_alu_valid;
  logic [NUM_REQ-1:0]          o_rsp_valid;
  logic [WIDTH-1:0]            o_rsp_result;
  logic                        o_rsp_zero;
  logic                        o_rsp_cf;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_req_op,
    input  i_alu_result, i_alu_zero, i_alu_cf, i_alu_valid,
    output o_req_ready, o_alu_a, o_alu_b, o_alu_opcode, o_alu_valid,
    output o_rsp_valid, o_rsp_result, o_rsp_zero, o_rsp_cf
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_req_op,
    output i_alu_result, i_alu_zero, i_alu_cf, i_alu_valid,
    input  o_req_ready, o_alu_a, o_alu_b, o_alu_opcode, o_alu_valid,
    input  o_rsp_valid, o_rsp_result, o_rsp_zero, o_rsp_cf
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one pipeline_alu between NUM_REQ requesters, with id tagging,
// result routing and an enable/drain FSM. Define ALU_ARB_STATS_EN to add o_grant_cnt.
`ifndef WORD
`define WORD 8
`endif
`ifndef OP_WIDTH
`define OP_WIDTH 4
`endif

module alu_arbiter #(
  parameter int WIDTH    = `WORD,
  parameter int OP_WIDTH = `OP_WIDTH,
  parameter int NUM_REQ  = 2,
  parameter int ALU_LAT  = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_enable,
  alu_arbiter_if.slave bus,
  output logic         o_idle,
  output logic         o_err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] o_grant_cnt
`endif
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ALU_LAT + 2);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                      state_r, state_nx_s;
  logic [ID_W-1:0]             ptr_r, ptr_nx_s, cand_s, gnt_id_s;
  logic                        found_s, hs_s, rsp_hit_s;
  logic [CNT_W-1:0]            cnt_r, cnt_nx_s;
  logic [ALU_LAT:0]            tag_vld_r;
  logic [ALU_LAT:0][ID_W-1:0]  tag_id_r;
  logic                        err_r, idle_r;
  logic [WIDTH-1:0]            alu_a_r, alu_b_r, rsp_result_r;
  logic [OP_WIDTH-1:0]         alu_op_r;
  logic                        alu_valid_r, rsp_zero_r, rsp_cf_r;
  logic [NUM_REQ-1:0]          rsp_valid_r;

  // Round-robin search for the first valid requester at or above the pointer
  always_comb begin
    found_s  = 1'b0;
    gnt_id_s = '0;
    cand_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = ID_W'((int'(ptr_r) + i) % NUM_REQ);
      if (!found_s && bus.i_req_valid[cand_s]) begin
        found_s  = 1'b1;
        gnt_id_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign hs_s      = found_s && (state_r == ST_RUN);
  assign ptr_nx_s  = (gnt_id_s == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_s + ID_W'(1);
  assign rsp_hit_s = bus.i_alu_valid && tag_vld_r[ALU_LAT];

  // In-flight count tracks tags in the pipe, so a lost ALU result cannot wedge a drain
  always_comb begin
    cnt_nx_s = cnt_r;
    if (hs_s && !tag_vld_r[ALU_LAT]) begin
      cnt_nx_s = cnt_r + CNT_W'(1);
    end else if (!hs_s && tag_vld_r[ALU_LAT]) begin
      cnt_nx_s = cnt_r - CNT_W'(1);
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // Enable/drain FSM next state
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_enable) state_nx_s = ST_RUN;
        else          state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (!i_enable) state_nx_s = ST_DRAIN;
        else           state_nx_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (i_enable)              state_nx_s = ST_RUN;
        else if (cnt_r == '0)      state_nx_s = ST_IDLE;
        else                       state_nx_s = ST_DRAIN;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Control state: FSM, pointer, counter, tag pipe, sticky error, idle flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      ptr_r     <= '0;
      cnt_r     <= '0;
      tag_vld_r <= '0;
      tag_id_r  <= '0;
      err_r     <= 1'b0;
      idle_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      ptr_r     <= hs_s ? ptr_nx_s : ptr_r;
      cnt_r     <= cnt_nx_s;
      tag_vld_r <= {tag_vld_r[ALU_LAT-1:0], hs_s};
      tag_id_r  <= {tag_id_r[ALU_LAT-1:0], gnt_id_s};
      err_r     <= err_r | (bus.i_alu_valid != tag_vld_r[ALU_LAT]);
      idle_r    <= (state_nx_s == ST_IDLE) && (cnt_nx_s == '0);
    end
  end

  // Registered issue to the ALU; operands hold between issues
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alu_valid_r <= 1'b0;
      alu_a_r     <= '0;
      alu_b_r     <= '0;
      alu_op_r    <= '0;
    end else begin
      alu_valid_r <= hs_s;
      if (hs_s) begin
        alu_a_r  <= bus.i_req_a[gnt_id_s*WIDTH +: WIDTH];
        alu_b_r  <= bus.i_req_b[gnt_id_s*WIDTH +: WIDTH];
        alu_op_r <= bus.i_req_op[gnt_id_s*OP_WIDTH +: OP_WIDTH];
      end
    end
  end

  // Registered response routed by the tag at the pipe tail
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_r  <= '0;
      rsp_result_r <= '0;
      rsp_zero_r   <= 1'b0;
      rsp_cf_r     <= 1'b0;
    end else if (rsp_hit_s) begin
      rsp_valid_r  <= ONE_HOT0 << tag_id_r[ALU_LAT];
      rsp_result_r <= bus.i_alu_result;
      rsp_zero_r   <= bus.i_alu_zero;
      rsp_cf_r     <= bus.i_alu_cf;
    end else begin
      rsp_valid_r  <= '0;
    end
  end

  assign bus.o_req_ready  = hs_s ? (ONE_HOT0 << gnt_id_s) : '0;
  assign bus.o_alu_a      = alu_a_r;
  assign bus.o_alu_b      = alu_b_r;
  assign bus.o_alu_opcode = alu_op_r;
  assign bus.o_alu_valid  = alu_valid_r;
  assign bus.o_rsp_valid  = rsp_valid_r;
  assign bus.o_rsp_result = rsp_result_r;
  assign bus.o_rsp_zero   = rsp_zero_r;
  assign bus.o_rsp_cf     = rsp_cf_r;
  assign o_idle           = idle_r;
  assign o_err            = err_r;

`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] gcnt_r;

  // Saturating per-requester grant counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gcnt_r <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (hs_s && (gnt_id_s == ID_W'(k)) && (gcnt_r[k] != 16'hFFFF)) begin
          gcnt_r[k] <= gcnt_r[k] + 16'd1;
        end
      end
    end
  end

  assign o_grant_cnt = gcnt_r;
`endif
endmodule
